// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide unit for the 5-stage pipeline.
// Owns HI/LO, runs mult/multu/div/divu over a fixed multi-cycle latency modelled by a
// busy counter, services mthi/mtlo/mfhi/mflo, and raises the D-stage stall for MD ops.
//
// Ports:
//   clk       clock
//   reset     synchronous, active-high; clears all state and aborts any operation
//   e_md_op   E-stage MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 none
//   e_a, e_b  forwarded rs / rt values
//   d_is_md   D-stage instruction is an MD-class op
//   busy      multi-cycle operation in progress
//   start     mult/div accepted this cycle (combinational)
//   md_rdata  HI for mfhi, LO for mflo, else 0 (combinational)
//   hi, lo    current HI / LO
//   stall_md  hold the MD-class instruction in D (combinational)
module mdu_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       e_md_op,
  input  logic [WIDTH-1:0] e_a,
  input  logic [WIDTH-1:0] e_b,
  input  logic             d_is_md,
  output logic             busy,
  output logic             start,
  output logic [WIDTH-1:0] md_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_md
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMfhi  = 4'd7,
    OpMflo  = 4'd8
  } md_op_e;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_skip_q, pend_skip_d;

  // Datapath results, evaluated every cycle and captured only on start.
  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic [WIDTH-1:0]          div_b;
  logic signed [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]          quo_u, rem_u;
  logic [WIDTH-1:0]          res_hi, res_lo;
  logic                      div_by_zero;
  logic                      is_mult;

  always_comb begin
    prod_s = $signed({{WIDTH{e_a[WIDTH-1]}}, e_a}) * $signed({{WIDTH{e_b[WIDTH-1]}}, e_b});
    prod_u = {{WIDTH{1'b0}}, e_a} * {{WIDTH{1'b0}}, e_b};
    // Substitute a divisor of 1 on zero so no X/trap leaks; the result is discarded anyway.
    div_b  = (e_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : e_b;
    quo_s  = $signed(e_a) / $signed(div_b);
    rem_s  = $signed(e_a) % $signed(div_b);
    quo_u  = e_a / div_b;
    rem_u  = e_a % div_b;
    is_mult     = (e_md_op == OpMult) || (e_md_op == OpMultu);
    div_by_zero = (e_b == '0) && ((e_md_op == OpDiv) || (e_md_op == OpDivu));
    res_hi = '0;
    res_lo = '0;
    case (e_md_op)
      OpMult:  begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      OpMultu: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      OpDiv:   begin res_hi = rem_s;                   res_lo = quo_s;             end
      OpDivu:  begin res_hi = rem_u;                   res_lo = quo_u;             end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_skip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_skip_q <= pend_skip_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_skip_d = pend_skip_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          cnt_d       = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
          pend_hi_d   = res_hi;
          pend_lo_d   = res_lo;
          pend_skip_d = div_by_zero;
        end else if (e_md_op == OpMthi) begin
          hi_d = e_a;
        end else if (e_md_op == OpMtlo) begin
          lo_d = e_a;
        end
      end
      StRun: begin
        // New ops and mthi/mtlo are ignored here; only the countdown advances.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (!pend_skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy  = (state_q == StRun);
    start = !busy && ((e_md_op == OpMult) || (e_md_op == OpMultu) ||
                      (e_md_op == OpDiv)  || (e_md_op == OpDivu));
    case (e_md_op)
      OpMfhi:  md_rdata = hi_q;
      OpMflo:  md_rdata = lo_q;
      default: md_rdata = '0;
    endcase
    hi       = hi_q;
    lo       = lo_q;
    // busy is still low in the start cycle, so start is folded in.
    stall_md = d_is_md && (start || busy);
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  e_md_op;
  logic [31:0] e_a, e_b;
  logic        d_is_md;
  logic        busy, start, stall_md;
  logic [31:0] md_rdata, hi, lo;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] sb[$];
  logic        abort_pending = 1'b0;
  logic        busy_prev = 1'b0;
  logic [31:0] model_hi = '0, model_lo = '0;

  localparam int PokeReset = 99;

  mdu_sequencer #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_md_op  (e_md_op),
    .e_a      (e_a),
    .e_b      (e_b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .start    (start),
    .md_rdata (md_rdata),
    .hi       (hi),
    .lo       (lo),
    .stall_md (stall_md)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare committed HI/LO when busy falls.
  always @(negedge clk) begin
    if (busy_prev && !busy) begin
      if (abort_pending) begin
        abort_pending = 1'b0;
      end else if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        check_eq("result", {hi, lo}, sb.pop_front());
      end
    end
    busy_prev = busy;
  end

  task automatic set_reg(input logic [3:0] op, input logic [31:0] val);
    @(posedge clk); #1;
    e_md_op = op;
    e_a     = val;
    @(negedge clk);
    check_eq("mt_start", 64'(start), 64'd0);
    @(posedge clk); #1;
    e_md_op = 4'd0;
    e_a     = '0;
    if (op == 4'd5) model_hi = val; else model_lo = val;
    @(negedge clk);
    check_eq("mt_hi", 64'(hi), 64'(model_hi));
    check_eq("mt_lo", 64'(lo), 64'(model_lo));
  endtask

  // Issue one mult/div, track its busy window and stall, optionally poke it mid-flight.
  task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic stall_en, input int poke);
    int          sa, sb_i, q, r, cnt, exp_len;
    longint      ps;
    logic [63:0] pu, expv;
    logic        done;
    sa = a;
    sb_i = b;
    case (op)
      4'd1: begin ps = longint'(sa) * longint'(sb_i); expv = ps; end
      4'd2: begin pu = {32'h0, a} * {32'h0, b}; expv = pu; end
      4'd3: begin
        if (b == 0) expv = {model_hi, model_lo};
        else begin q = sa / sb_i; r = sa % sb_i; expv = {r, q}; end
      end
      default: begin
        if (b == 0) expv = {model_hi, model_lo};
        else expv = {a % b, a / b};
      end
    endcase
    exp_len = (poke == PokeReset) ? 2 : ((op <= 4'd2) ? 5 : 10);
    sb.push_back(expv);
    model_hi = expv[63:32];
    model_lo = expv[31:0];
    @(posedge clk); #1;
    e_md_op = op;
    e_a     = a;
    e_b     = b;
    d_is_md = stall_en;
    @(negedge clk);
    check_eq("start", 64'(start), 64'd1);
    check_eq("busy_at_start", 64'(busy), 64'd0);
    check_eq("stall_start", 64'(stall_md), 64'(stall_en));
    @(posedge clk); #1;
    e_md_op = 4'd0;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        cnt++;
        check_eq("stall_busy", 64'(stall_md), 64'(stall_en));
        if (cnt == 2 && poke == PokeReset) begin
          reset = 1'b1;
          abort_pending = 1'b1;
          sb.delete();
        end else if (cnt == 3 && poke != 0 && poke != PokeReset) begin
          e_md_op = 4'(poke);
          e_a     = 32'hDEADBEEF;
          e_b     = 32'd3;
          #1;
          check_eq("start_while_busy", 64'(start), 64'd0);
        end else if (cnt == 4) begin
          e_md_op = 4'd0;
        end
      end
    end
    if (!done) check_eq("busy_timeout", 64'(busy), 64'd0);
    e_md_op = 4'd0;
    check_eq("busy_len", 64'(cnt), 64'(exp_len));
    check_eq("stall_after", 64'(stall_md), 64'd0);
    if (poke == PokeReset) begin
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
      check_eq("abort_hi", 64'(hi), 64'd0);
      check_eq("abort_lo", 64'(lo), 64'd0);
    end
    d_is_md = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset   = 1'b1;
    e_md_op = '0;
    e_a     = '0;
    e_b     = '0;
    d_is_md = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e_md_op = 4'd8;
    d_is_md = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_rdata", 64'(md_rdata), 64'd0);
    check_eq("rst_stall", 64'(stall_md), 64'd0);
    reset   = 1'b0;
    e_md_op = '0;
    d_is_md = 1'b0;

    // Directed arithmetic.
    do_md(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
    check_eq("t1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    do_md(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
    check_eq("t2_multu", {hi, lo}, 64'h00000001_FFFFFFFE);
    do_md(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    check_eq("t2_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_md(4'd4, 32'd7, 32'd2, 1'b0, 0);
    check_eq("t2_divu", {hi, lo}, 64'h00000001_00000003);

    // mthi/mtlo and same-cycle mfhi/mflo.
    set_reg(4'd5, 32'h12345678);
    set_reg(4'd6, 32'h0000ABCD);
    @(posedge clk); #1;
    e_md_op = 4'd8;
    #1 check_eq("mflo", 64'(md_rdata), 64'h0000ABCD);
    e_md_op = 4'd7;
    #1 check_eq("mfhi", 64'(md_rdata), 64'h12345678);
    e_md_op = 4'd12;
    #1 check_eq("rdata_none", 64'(md_rdata), 64'd0);
    check_eq("start_op12", 64'(start), 64'd0);
    e_md_op = 4'd0;

    // Stall covers start + busy; non-MD in D never stalls.
    do_md(4'd3, 32'd100, 32'd7, 1'b1, 0);
    do_md(4'd3, 32'd100, 32'd7, 1'b0, 0);

    // Divide by zero leaves HI/LO; ops during busy are ignored.
    set_reg(4'd5, 32'h11);
    set_reg(4'd6, 32'h22);
    do_md(4'd3, 32'd5, 32'd0, 1'b1, 1);
    check_eq("dz_hilo", {hi, lo}, 64'h00000011_00000022);
    do_md(4'd4, 32'd9, 32'd0, 1'b0, 5);
    check_eq("dz_mthi_busy", {hi, lo}, 64'h00000011_00000022);
    do_md(4'd4, 32'd9, 32'd0, 1'b0, 6);
    check_eq("dz_mtlo_busy", {hi, lo}, 64'h00000011_00000022);

    // Reset mid-mult aborts, then a fresh mult completes normally.
    do_md(4'd1, 32'd6, 32'd7, 1'b1, PokeReset);
    do_md(4'd1, 32'd6, 32'd7, 1'b0, 0);
    check_eq("post_reset_mult", {hi, lo}, 64'd42);

    // Randomised operations against the scoreboard.
    for (int i = 0; i < 8; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (rop == 4'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      do_md(rop, ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- E-stage multiply/divide unit with its own sequencer for the 5-stage pipeline.
- Owns the HI/LO registers and accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage controller.
- Models multi-cycle latency with a busy counter.
- Produces the D-stage stall request that holds any MD-class instruction in D while an operation is pending.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high; clears all state.
- e_md_op  input  4  E-stage MD operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- e_a  input  WIDTH  forwarded rs value.
- e_b  input  WIDTH  forwarded rt value.
- d_is_md  input  1  D-stage instruction is any MD-class op (codes 1-8).
- busy  output  1  operation in progress.
- start  output  1  combinational; e_md_op in 1..4 and busy=0.
- md_rdata  output  WIDTH  combinational; HI for op 7, LO for op 8, else 0.
- hi  output  WIDTH  current HI.
- lo  output  WIDTH  current LO.
- stall_md  output  1  combinational; d_is_md & (start | busy).

Behaviour:

Reset and latency
- Reset (sync, high) values: busy=0, counter=0, hi=0, lo=0, pending results=0.
- Reset mid-operation aborts it: HI/LO stay 0 and the pending result is discarded.
- Latency: start in cycle T.
  - Counter loads N at the edge ending T (N=MULT_CYCLES or DIV_CYCLES).
  - busy=1 for cycles T+1..T+N.
  - HI/LO take the pending result at the edge ending T+N.
  - The new values are visible, with busy=0, from T+N+1.

States
- IDLE (counter=0): start -> RUN.
- RUN (counter!=0): the counter decrements each cycle. When counter==1 at the edge, commit and go to IDLE.
- No other states.

Arithmetic (captured at the start edge into pending_hi/pending_lo)
- mult: signed 64-bit product of e_a and e_b; HI=[63:32], LO=[31:0].
- multu: unsigned 64-bit product.
- div: signed; LO=quotient truncated toward zero, HI=remainder carrying the dividend's sign.
- divu: unsigned quotient/remainder.
- Divide by zero (e_b=0, op 3/4): busy sequence runs normally, but HI/LO are left unchanged at commit.

mthi/mtlo
- When busy=0: write e_a into HI/LO at the clock edge, with a one-cycle effect.
- While busy=1: ignored. The pipeline stall makes this unreachable; the bench checks it anyway.

Start while busy
- A mult/div op presented while busy=1 is ignored: counter and pending values are untouched and start=0.

mfhi/mflo
- Read the current HI/LO combinationally.
- No bypass of pending results. Correctness depends on stall_md keeping them in D until busy=0.

Stall
- stall_md covers the start cycle itself, since busy is not yet high.
- A non-MD instruction in D never stalls on this unit.
- The pipeline applies stall_md ORed with the hazard stall: freeze PC and FD, clear DE.

Simultaneous events
- Commit edge plus a new start in the cycle after busy drops: the commit is already done, so the sequence proceeds normally.
- Reset has priority over every other event.

Test Plan:
1. mult, e_a=0xFFFFFFFF, e_b=2, start at T -> busy high for T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
2. multu, same operands -> hi=0x00000001, lo=0xFFFFFFFE at T+6. div, e_a=0xFFFFFFF9 (-7), e_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+11. divu, 7/2 -> lo=3, hi=1.
3. mthi e_a=0x12345678 when idle -> hi=0x12345678 next cycle. Then mflo with lo=0xABCD -> md_rdata=0x0000ABCD in the same cycle.
4. Start div; hold d_is_md=1 -> stall_md=1 in T and T+1..T+10, and 0 at T+11. d_is_md=0 during busy -> stall_md=0.
5. div with e_b=0 and hi/lo preloaded 0x11/0x22 -> busy runs 10 cycles, then hi=0x11, lo=0x22. mult presented at T+3 while busy -> ignored, result from the first op only.
6. Assert reset at T+2 of a mult -> next cycle busy=0, hi=lo=0, stall_md=0. A new mult afterwards completes normally in 5 cycles.
